// File: rtl/mac_acc_pipe.sv
// Pipelined LANES-wide dot-product MAC feeding a saturating per-group accumulator.
// S1 registers lane products, S2 the adder-tree sum, S3 accumulates and emits on a last beat.
module mac_acc_pipe #(
  parameter int LANES = 8,
  parameter int DW    = 8,
  parameter int ACCW  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   in_data,
  input  logic [LANES*DW-1:0]   in_weight,
  input  logic                  in_signed,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACCW-1:0]       out_result,
  output logic                  out_sat,
  output logic [15:0]           out_beats
);

  localparam int PW = 2*DW + 2;
  localparam int SW = PW + $clog2(LANES);
  localparam int XW = ACCW + 2;
  localparam logic signed [XW-1:0] SMAX = {3'b000, {(ACCW-1){1'b1}}};
  localparam logic signed [XW-1:0] SMIN = {3'b111, {(ACCW-1){1'b0}}};
  localparam logic signed [XW-1:0] UMAX = {2'b00, {ACCW{1'b1}}};
  localparam logic signed [XW-1:0] UMIN = {XW{1'b0}};

  logic                 w_en;
  logic                 w_accept;
  logic                 w_mode;
  logic signed [DW:0]   w_op_a [LANES];
  logic signed [DW:0]   w_op_b [LANES];
  logic signed [PW-1:0] w_prod [LANES];
  logic signed [SW-1:0] w_sum;
  logic signed [XW-1:0] w_base;
  logic signed [XW-1:0] w_total;
  logic [ACCW-1:0]      w_acc_nxt;
  logic                 w_clip;
  logic                 w_sat_nxt;
  logic [15:0]          w_cnt_nxt;

  logic                 r_mode;
  logic                 r_s1_valid;
  logic                 r_s1_first;
  logic                 r_s1_last;
  logic                 r_s1_mode;
  logic signed [PW-1:0] r_s1_prod [LANES];
  logic                 r_s2_valid;
  logic                 r_s2_first;
  logic                 r_s2_last;
  logic                 r_s2_mode;
  logic signed [SW-1:0] r_s2_sum;
  logic [ACCW-1:0]      r_acc;
  logic                 r_sat;
  logic [15:0]          r_cnt;

  // A pending, unaccepted result freezes the whole pipeline.
  assign w_en     = !(out_valid && !out_ready);
  assign in_ready = w_en;
  assign w_accept = in_valid && w_en;
  assign w_mode   = in_first ? in_signed : r_mode;

  // Extend each operand by the group mode and form exact lane products.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      w_op_a[i] = {w_mode & in_data[i*DW+DW-1], in_data[i*DW +: DW]};
      w_op_b[i] = {w_mode & in_weight[i*DW+DW-1], in_weight[i*DW +: DW]};
      w_prod[i] = PW'(w_op_a[i]) * PW'(w_op_b[i]);
    end
  end

  // Group mode latch, updated only by an accepted first beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode <= 1'b0;
    end else if (w_accept && in_first) begin
      r_mode <= in_signed;
    end
  end

  // S1: lane products plus beat flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_prod[i] <= {PW{1'b0}};
      end
    end else if (w_en) begin
      r_s1_valid <= w_accept;
      r_s1_first <= in_first;
      r_s1_last  <= in_last;
      r_s1_mode  <= w_mode;
      for (int i = 0; i < LANES; i++) begin
        r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  // Adder tree over the registered products; SW bits cannot overflow.
  always_comb begin
    w_sum = {SW{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + SW'(r_s1_prod[i]);
    end
  end

  // S2: tree sum plus beat flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_first <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_mode  <= 1'b0;
      r_s2_sum   <= {SW{1'b0}};
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      r_s2_first <= r_s1_first;
      r_s2_last  <= r_s1_last;
      r_s2_mode  <= r_s1_mode;
      r_s2_sum   <= w_sum;
    end
  end

  // Next accumulator value: widened add, then clamp to the group's signed/unsigned range.
  always_comb begin
    if (r_s2_first) begin
      w_base = {XW{1'b0}};
    end else if (r_s2_mode) begin
      w_base = XW'($signed(r_acc));
    end else begin
      w_base = XW'(r_acc);
    end
    w_total = w_base + XW'(r_s2_sum);
    if (r_s2_mode) begin
      if (w_total > SMAX) begin
        w_acc_nxt = SMAX[ACCW-1:0];
        w_clip    = 1'b1;
      end else if (w_total < SMIN) begin
        w_acc_nxt = SMIN[ACCW-1:0];
        w_clip    = 1'b1;
      end else begin
        w_acc_nxt = w_total[ACCW-1:0];
        w_clip    = 1'b0;
      end
    end else begin
      if (w_total > UMAX) begin
        w_acc_nxt = UMAX[ACCW-1:0];
        w_clip    = 1'b1;
      end else if (w_total < UMIN) begin
        w_acc_nxt = UMIN[ACCW-1:0];
        w_clip    = 1'b1;
      end else begin
        w_acc_nxt = w_total[ACCW-1:0];
        w_clip    = 1'b0;
      end
    end
    w_sat_nxt = (r_s2_first ? 1'b0 : r_sat) | w_clip;
    if (r_s2_first) begin
      w_cnt_nxt = 16'd1;
    end else if (r_cnt == 16'hFFFF) begin
      w_cnt_nxt = r_cnt;
    end else begin
      w_cnt_nxt = r_cnt + 16'd1;
    end
  end

  // S3: accumulator state and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc      <= {ACCW{1'b0}};
      r_sat      <= 1'b0;
      r_cnt      <= 16'd0;
      out_valid  <= 1'b0;
      out_result <= {ACCW{1'b0}};
      out_sat    <= 1'b0;
      out_beats  <= 16'd0;
    end else if (w_en) begin
      if (r_s2_valid) begin
        r_acc <= w_acc_nxt;
        r_sat <= w_sat_nxt;
        r_cnt <= w_cnt_nxt;
      end
      // With en high any held result is transferring now, so a new one may replace it.
      if (r_s2_valid && r_s2_last) begin
        out_valid  <= 1'b1;
        out_result <= w_acc_nxt;
        out_sat    <= w_sat_nxt;
        out_beats  <= w_cnt_nxt;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_acc_pipe.sv
// Randomized and directed bench for mac_acc_pipe; runs ACCW=32 and ACCW=20 instances in lockstep
// against an arithmetic group model.
module tb_mac_acc_pipe;

  typedef struct packed {
    logic [31:0] res;
    logic        sat;
    logic [15:0] beats;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_signed, in_first, in_last, out_ready;
  logic [63:0] in_data, in_weight;
  logic        a_in_ready, a_out_valid, a_out_sat;
  logic [31:0] a_out_result;
  logic [15:0] a_out_beats;
  logic        b_in_ready, b_out_valid, b_out_sat;
  logic [19:0] b_out_result;
  logic [15:0] b_out_beats;

  int     total = 0;
  int     bad = 0;
  int     cyc = 0;
  rec_t   exp_a[$], exp_b[$], got_a[$], got_b[$];
  longint m_raw[2];
  logic   m_sat[2];
  int     m_cnt[2];
  logic   m_mode;
  logic   last_acc;
  logic   rnd_rdy = 1'b0;

  always #5 clk = ~clk;

  mac_acc_pipe #(.LANES(8), .DW(8), .ACCW(32)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_signed(in_signed),
    .in_first(in_first), .in_last(in_last), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_result(a_out_result), .out_sat(a_out_sat),
    .out_beats(a_out_beats)
  );

  mac_acc_pipe #(.LANES(8), .DW(8), .ACCW(20)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_weight(in_weight), .in_signed(in_signed),
    .in_first(in_first), .in_last(in_last), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_result(b_out_result), .out_sat(b_out_sat),
    .out_beats(b_out_beats)
  );

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_raw[k] = 0;
      m_sat[k] = 1'b0;
      m_cnt[k] = 0;
    end
    m_mode = 1'b0;
  endtask

  // Group semantics in plain integer arithmetic: dot product, widen, clamp, sticky flag, count.
  task automatic model_beat();
    longint s, av, wv, base, t, hi, lo;
    logic [7:0] a8, w8;
    logic clip;
    int W;
    rec_t r;
    if (in_first) m_mode = in_signed;
    s = 0;
    for (int i = 0; i < 8; i++) begin
      a8 = in_data[i*8 +: 8];
      w8 = in_weight[i*8 +: 8];
      av = m_mode ? longint'($signed(a8)) : longint'(a8);
      wv = m_mode ? longint'($signed(w8)) : longint'(w8);
      s += av * wv;
    end
    for (int k = 0; k < 2; k++) begin
      W = (k == 0) ? 32 : 20;
      if (in_first) base = 0;
      else if (m_mode && m_raw[k][W-1]) base = m_raw[k] - (64'sd1 << W);
      else base = m_raw[k];
      t = base + s;
      if (m_mode) begin
        hi = (64'sd1 << (W-1)) - 64'sd1;
        lo = -(64'sd1 << (W-1));
      end else begin
        hi = (64'sd1 << W) - 64'sd1;
        lo = 64'sd0;
      end
      clip = 1'b0;
      if (t > hi) begin t = hi; clip = 1'b1; end
      else if (t < lo) begin t = lo; clip = 1'b1; end
      m_raw[k] = t & ((64'sd1 << W) - 64'sd1);
      m_sat[k] = (in_first ? 1'b0 : m_sat[k]) | clip;
      m_cnt[k] = in_first ? 1 : ((m_cnt[k] >= 65535) ? 65535 : m_cnt[k] + 1);
      if (in_last) begin
        r.res   = m_raw[k][31:0];
        r.sat   = m_sat[k];
        r.beats = m_cnt[k][15:0];
        if (k == 0) exp_a.push_back(r);
        else exp_b.push_back(r);
      end
    end
  endtask

  // One clock: record transfers and accepted beats for the posedge ahead, end on the next negedge.
  task automatic tick();
    logic xa, xb;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    #1;
    last_acc = in_valid && a_in_ready && !rst;
    xa = a_out_valid && out_ready && !rst;
    xb = b_out_valid && out_ready && !rst;
    if (xa) got_a.push_back(rec_t'({a_out_result, a_out_sat, a_out_beats}));
    if (xb) got_b.push_back(rec_t'({12'd0, b_out_result, b_out_sat, b_out_beats}));
    if (rst) model_reset();
    else if (last_acc) model_beat();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [63:0] w,
                           input logic sg, input logic f, input logic l);
    int n;
    in_data = d; in_weight = w; in_signed = sg; in_first = f; in_last = l;
    in_valid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    total++;
    if (!last_acc) begin
      bad++;
      $display("FAIL send_beat timeout: accepted=%0b after %0d cycles, required 1", last_acc, n);
    end
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((got_a.size() < exp_a.size() || got_b.size() < exp_b.size()) && n < 100) begin
      tick();
      n++;
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  function automatic logic [63:0] fill(input logic [7:0] v);
    return {8{v}};
  endfunction

  function automatic logic [63:0] lane0(input logic [7:0] v);
    return {56'd0, v};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_data = 64'd0; in_weight = 64'd0; in_signed = 1'b0; in_first = 1'b0; in_last = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_out_result !== 32'd0 || a_out_sat !== 1'b0 ||
        a_out_beats !== 16'd0 || a_in_ready !== 1'b1 || b_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset: valid=%b result=%0h sat=%b beats=%0d ready=%b, required 0 0 0 0 1",
               a_out_valid, a_out_result, a_out_sat, a_out_beats, a_in_ready);
    end
  endtask

  task automatic test_single();
    rec_t ga, gb, ea, eb;
    send_beat(fill(8'h80), fill(8'h80), 1'b1, 1'b1, 1'b1);
    send_beat(fill(8'hFF), fill(8'hFF), 1'b0, 1'b1, 1'b1);
    drain();
    if (got_a.size() >= 2) begin
      total++;
      if (got_a[0] !== rec_t'({32'd131072, 1'b0, 16'd1}) || got_a[1] !== rec_t'({32'd520200, 1'b0, 16'd1})) begin
        bad++;
        $display("FAIL single const: got %0d/%b/%0d and %0d/%b/%0d, required 131072/0/1 and 520200/0/1",
                 got_a[0].res, got_a[0].sat, got_a[0].beats, got_a[1].res, got_a[1].sat, got_a[1].beats);
      end
    end
    total++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      bad++;
      $display("FAIL single count: got a=%0d b=%0d, required a=%0d b=%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0 && got_b.size() > 0 && exp_b.size() > 0) begin
      ga = got_a.pop_front(); ea = exp_a.pop_front(); gb = got_b.pop_front(); eb = exp_b.pop_front();
      total++;
      if (ga !== ea || gb !== eb) begin
        bad++;
        $display("FAIL single result: got a=%h b=%h, required a=%h b=%h", ga, gb, ea, eb);
      end
    end
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_back_to_back();
    rec_t ga, gb, ea, eb;
    int c0;
    c0 = cyc;
    send_beat(lane0(8'd10), lane0(8'd10), 1'b1, 1'b1, 1'b0);
    send_beat(lane0(8'hF1), lane0(8'd20), 1'b0, 1'b0, 1'b0);
    send_beat(lane0(8'd7), lane0(8'd1), 1'b0, 1'b0, 1'b0);
    send_beat(64'd0, 64'd0, 1'b0, 1'b0, 1'b1);
    in_valid = 1'b0;
    total++;
    if (cyc - c0 != 4) begin
      bad++;
      $display("FAIL b2b throughput: got %0d cycles for 4 beats, required 4", cyc - c0);
    end
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b latency t+1: out_valid=%b, required 0", a_out_valid);
    end
    tick();
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b latency t+2: out_valid=%b, required 0", a_out_valid);
    end
    tick();
    total++;
    if (a_out_valid !== 1'b1 || a_out_result !== 32'hFFFFFF3F || a_out_beats !== 16'd4) begin
      bad++;
      $display("FAIL b2b latency t+3: valid=%b result=%0d beats=%0d, required 1 -193 4",
               a_out_valid, $signed(a_out_result), a_out_beats);
    end
    drain();
    total++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      bad++;
      $display("FAIL b2b count: got a=%0d b=%0d, required a=%0d b=%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0 && got_b.size() > 0 && exp_b.size() > 0) begin
      ga = got_a.pop_front(); ea = exp_a.pop_front(); gb = got_b.pop_front(); eb = exp_b.pop_front();
      total++;
      if (ga !== ea || gb !== eb) begin
        bad++;
        $display("FAIL b2b result: got a=%h b=%h, required a=%h b=%h", ga, gb, ea, eb);
      end
    end
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_saturation();
    rec_t ga, gb, ea, eb;
    for (int i = 0; i < 4; i++) begin
      send_beat(fill(8'h80), fill(8'h80), 1'b1, (i == 0), (i == 3));
    end
    send_beat(lane0(8'd5), lane0(8'd1), 1'b1, 1'b1, 1'b1);
    drain();
    if (got_b.size() >= 2 && got_a.size() >= 1) begin
      total++;
      if (got_b[0] !== rec_t'({32'd524287, 1'b1, 16'd4}) || got_b[1] !== rec_t'({32'd5, 1'b0, 16'd1}) ||
          got_a[0] !== rec_t'({32'd524288, 1'b0, 16'd4})) begin
        bad++;
        $display("FAIL sat const: got b=%0d/%b/%0d then %0d/%b/%0d a=%0d, required 524287/1/4 then 5/0/1 a=524288",
                 got_b[0].res, got_b[0].sat, got_b[0].beats, got_b[1].res, got_b[1].sat, got_b[1].beats, got_a[0].res);
      end
    end
    total++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      bad++;
      $display("FAIL sat count: got a=%0d b=%0d, required a=%0d b=%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0 && got_b.size() > 0 && exp_b.size() > 0) begin
      ga = got_a.pop_front(); ea = exp_a.pop_front(); gb = got_b.pop_front(); eb = exp_b.pop_front();
      total++;
      if (ga !== ea || gb !== eb) begin
        bad++;
        $display("FAIL sat result: got a=%h b=%h, required a=%h b=%h", ga, gb, ea, eb);
      end
    end
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_backpressure();
    rec_t ga, gb, ea, eb;
    logic [31:0] hold_a;
    logic [19:0] hold_b;
    logic [63:0] d4, w4;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    d4 = {$urandom, $urandom};
    w4 = {$urandom, $urandom};
    in_data = d4; in_weight = w4; in_signed = 1'b1; in_first = 1'b1; in_last = 1'b1;
    hold_a = a_out_result;
    hold_b = b_out_result;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (a_in_ready !== 1'b0 || b_in_ready !== 1'b0 || a_out_valid !== 1'b1 ||
          a_out_result !== hold_a || b_out_result !== hold_b) begin
        bad++;
        $display("FAIL stall hold: ready=%b valid=%b result=%h/%h, required 0 1 %h/%h",
                 a_in_ready, a_out_valid, a_out_result, b_out_result, hold_a, hold_b);
      end
    end
    out_ready = 1'b1;
    send_beat(d4, w4, 1'b1, 1'b1, 1'b1);
    drain();
    total++;
    if (got_a.size() != 4 || exp_a.size() != 4 || got_b.size() != 4) begin
      bad++;
      $display("FAIL stall count: got a=%0d b=%0d, required 4 (model %0d)", got_a.size(), got_b.size(), exp_a.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0 && got_b.size() > 0 && exp_b.size() > 0) begin
      ga = got_a.pop_front(); ea = exp_a.pop_front(); gb = got_b.pop_front(); eb = exp_b.pop_front();
      total++;
      if (ga !== ea || gb !== eb) begin
        bad++;
        $display("FAIL stall result: got a=%h b=%h, required a=%h b=%h", ga, gb, ea, eb);
      end
    end
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_reset_midgroup();
    rec_t ga, gb, ea, eb;
    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b1, 1'b0);
    send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_out_result !== 32'd0 || a_out_sat !== 1'b0 ||
        a_out_beats !== 16'd0 || a_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL midreset: valid=%b result=%0h sat=%b beats=%0d ready=%b, required 0 0 0 0 1",
               a_out_valid, a_out_result, a_out_sat, a_out_beats, a_in_ready);
    end
    send_beat(lane0(8'd6), lane0(8'd7), 1'b1, 1'b1, 1'b1);
    drain();
    total++;
    if (got_a.size() != 1 || got_a[0] !== rec_t'({32'd42, 1'b0, 16'd1}) || got_b.size() != exp_b.size()) begin
      bad++;
      $display("FAIL midreset after: got %0d results, first=%h, required 1 result 42/0/1", got_a.size(),
               (got_a.size() > 0) ? got_a[0] : rec_t'(49'd0));
    end
    while (got_a.size() > 0 && exp_a.size() > 0 && got_b.size() > 0 && exp_b.size() > 0) begin
      ga = got_a.pop_front(); ea = exp_a.pop_front(); gb = got_b.pop_front(); eb = exp_b.pop_front();
      total++;
      if (ga !== ea || gb !== eb) begin
        bad++;
        $display("FAIL midreset result: got a=%h b=%h, required a=%h b=%h", ga, gb, ea, eb);
      end
    end
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  task automatic test_random();
    rec_t ga, gb, ea, eb;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 80; i++) begin
      send_beat({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 4) == 0) begin
        in_valid = 1'b0;
        tick();
      end
    end
    rnd_rdy = 1'b0;
    drain();
    total++;
    if (got_a.size() != exp_a.size() || got_b.size() != exp_b.size()) begin
      bad++;
      $display("FAIL random count: got a=%0d b=%0d, required a=%0d b=%0d", got_a.size(), got_b.size(), exp_a.size(), exp_b.size());
    end
    while (got_a.size() > 0 && exp_a.size() > 0 && got_b.size() > 0 && exp_b.size() > 0) begin
      ga = got_a.pop_front(); ea = exp_a.pop_front(); gb = got_b.pop_front(); eb = exp_b.pop_front();
      total++;
      if (ga !== ea || gb !== eb) begin
        bad++;
        $display("FAIL random result: got a=%h b=%h, required a=%h b=%h", ga, gb, ea, eb);
      end
    end
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_back_to_back();
    test_saturation();
    test_backpressure();
    test_reset_midgroup();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
